// File: rtl/moore_pattern_gen_if.sv
// moore_pattern_gen_if: request and serial-output bundle of the pattern generator
interface moore_pattern_gen_if #(parameter int PW = 8);
    logic          start;
    logic [PW-1:0] pattern;
    logic [2:0]    len;
    logic          w_out;
    logic          busy;
    logic          done;
    logic [1:0]    tt_ht;
    modport master (output start, pattern, len, input w_out, busy, done, tt_ht);
    modport slave  (input start, pattern, len, output w_out, busy, done, tt_ht);
endinterface

// File: rtl/moore_pattern_gen.sv
// moore_pattern_gen: Moore FSM serialising a pattern MSB first, DIV cycles per bit; PATTERN_REPEAT_EN enables frame repeat
module moore_pattern_gen #(
    parameter int DIV = 50000000,
    parameter int PW  = 8
) (
    input logic                 Clock,
    input logic                 Resetn,
    moore_pattern_gen_if.slave  bus
);
    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] SEND = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] shift_reg_q, shift_reg_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;
`ifdef PATTERN_REPEAT_EN
    logic [PW-1:0] save_pat_q, save_pat_d;
    logic [2:0]    save_len_q, save_len_d;
`endif

    assign tick = tick_cnt_q == TW'(DIV - 1);

    // Outputs come only from registered state so w_out feeds a Moore detector glitch-free
    assign bus.w_out = (state_q == SEND) & shift_reg_q[PW-1];
    assign bus.busy  = state_q == SEND;
    assign bus.done  = state_q == DONE;
    assign bus.tt_ht = state_q;

    // Next-state: capture in IDLE, hold each bit DIV cycles in SEND, one-cycle DONE
    always_comb begin
        state_d     = state_q;
        shift_reg_d = shift_reg_q;
        bit_cnt_d   = bit_cnt_q;
        tick_cnt_d  = tick_cnt_q;
`ifdef PATTERN_REPEAT_EN
        save_pat_d  = save_pat_q;
        save_len_d  = save_len_q;
`endif
        case (state_q)
            IDLE: if (bus.start) begin
                state_d     = SEND;
                shift_reg_d = bus.pattern;
                bit_cnt_d   = bus.len;
                tick_cnt_d  = '0;
`ifdef PATTERN_REPEAT_EN
                save_pat_d  = bus.pattern;
                save_len_d  = bus.len;
`endif
            end
            SEND: begin
                tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
                if (tick) begin
                    if (bit_cnt_q == 3'd0) state_d = DONE;
                    else begin
                        shift_reg_d = shift_reg_q << 1;
                        bit_cnt_d   = bit_cnt_q - 3'd1;
                    end
                end
            end
            DONE: begin
`ifdef PATTERN_REPEAT_EN
                state_d = bus.start ? SEND : IDLE;
                if (bus.start) begin
                    shift_reg_d = save_pat_q;
                    bit_cnt_d   = save_len_q;
                    tick_cnt_d  = '0;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any transfer at once
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= IDLE;
            shift_reg_q <= '0;
            bit_cnt_q   <= '0;
            tick_cnt_q  <= '0;
`ifdef PATTERN_REPEAT_EN
            save_pat_q  <= '0;
            save_len_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            shift_reg_q <= shift_reg_d;
            bit_cnt_q   <= bit_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
`ifdef PATTERN_REPEAT_EN
            save_pat_q  <= save_pat_d;
            save_len_q  <= save_len_d;
`endif
        end
    end
endmodule

// File: tb/tb_moore_pattern_gen.sv
// tb_moore_pattern_gen: directed checks of the pattern generator with DIV=4
module tb_moore_pattern_gen;
    localparam int DIV = 4;

    logic Clock = 1'b0;
    logic Resetn = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    moore_pattern_gen_if #(.PW(8)) bus ();

    moore_pattern_gen #(.DIV(DIV), .PW(8)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus.slave)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tt"}, 8'(bus.tt_ht), 8'd0);
        check({tag, "_w"}, 8'(bus.w_out), 8'd0);
        check({tag, "_busy"}, 8'(bus.busy), 8'd0);
        check({tag, "_done"}, 8'(bus.done), 8'd0);
    endtask

    task automatic check_done(input string tag);
        check({tag, "_tt"}, 8'(bus.tt_ht), 8'd2);
        check({tag, "_w"}, 8'(bus.w_out), 8'd0);
        check({tag, "_busy"}, 8'(bus.busy), 8'd0);
        check({tag, "_done"}, 8'(bus.done), 8'd1);
    endtask

    // Checks every SEND cycle of a frame; returns at the negedge after the last one
    task automatic check_frame(input string tag, input logic [7:0] p, input int l, input bit disturb);
        for (int i = 0; i < (l + 1) * DIV; i++) begin
            if (disturb) begin
                bus.start = i[0];
                bus.pattern = 8'h00;
                bus.len = 3'd7;
            end
            check({tag, "_w"}, 8'(bus.w_out), 8'(p[7 - i / DIV]));
            check({tag, "_busy"}, 8'(bus.busy), 8'd1);
            check({tag, "_tt"}, 8'(bus.tt_ht), 8'd1);
            check({tag, "_done"}, 8'(bus.done), 8'd0);
            @(negedge Clock);
        end
    endtask

    task automatic launch(input logic [7:0] p, input logic [2:0] l);
        @(negedge Clock);
        bus.start = 1'b1;
        bus.pattern = p;
        bus.len = l;
        @(negedge Clock);
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.pattern = 8'h00;
        bus.len = 3'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            check_idle("rst");
        end
        Resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            check_idle("idle");
        end

        launch(8'b1101_0000, 3'd3);
        check_frame("basic", 8'b1101_0000, 3, 1'b0);
        check_done("basic_done");
        @(negedge Clock);
        check_idle("basic_end");

        launch(8'h80, 3'd0);
        check_frame("single", 8'h80, 0, 1'b0);
        check_done("single_done");
        @(negedge Clock);
        check_idle("single_end");

        launch(8'b1101_0000, 3'd3);
        check_frame("ignore", 8'b1101_0000, 3, 1'b1);
        bus.start = 1'b0;
        check_done("ignore_done");
        @(negedge Clock);
        check_idle("ignore_end");

        launch(8'b1101_0000, 3'd3);
        for (int i = 0; i < 5; i++) @(negedge Clock);
        check("pre_rst_busy", 8'(bus.busy), 8'd1);
        #2 Resetn = 1'b0;
        #1 check_idle("async_rst");
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            check_idle("held_rst");
        end
        Resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            check_idle("post_rst");
        end
        launch(8'h80, 3'd0);
        check_frame("after_rst", 8'h80, 0, 1'b0);
        check_done("after_rst_done");
        @(negedge Clock);
        check_idle("after_rst_end");

`ifdef PATTERN_REPEAT_EN
        @(negedge Clock);
        bus.start = 1'b1;
        bus.pattern = 8'b1100_0000;
        bus.len = 3'd1;
        @(negedge Clock);
        check_frame("rep1", 8'b1100_0000, 1, 1'b0);
        check_done("rep1_gap");
        @(negedge Clock);
        bus.start = 1'b0;
        check_frame("rep2", 8'b1100_0000, 1, 1'b0);
        check_done("rep2_done");
        @(negedge Clock);
        check_idle("rep_end");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
